// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle for the HI/LO multiply-divide unit.
// master drives requests, slave returns status and HI/LO.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MUL/DIV with architectural HI/LO.
// One shift-add / restoring shift-subtract step per cycle, then a sign fix.
module muldiv_unit (
    input  logic         clk,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic [31:0] r_src_a;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dz;

    logic        w_idle;
    logic        w_md_go;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_sgn;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_sh;
    logic        w_div_ok;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    // decode the request and prepare unsigned operand magnitudes
    always_comb begin
        w_idle  = (r_state == S_IDLE);
        w_md_go = 1'b0;
        w_mthi  = 1'b0;
        w_mtlo  = 1'b0;
        if (w_idle && bus.start) begin
            unique case (1'b1)
                !bus.op[2]:                w_md_go = 1'b1;
                bus.op == 3'b100:          w_mthi  = 1'b1;
                bus.op == 3'b101:          w_mtlo  = 1'b1;
                default:                   w_md_go = 1'b0;
            endcase
        end
        w_sgn   = bus.op[0];
        w_abs_a = (w_sgn && bus.src_a[31]) ? (~bus.src_a + 32'd1)
                                           : bus.src_a;
        w_abs_b = (w_sgn && bus.src_b[31]) ? (~bus.src_b + 32'd1)
                                           : bus.src_b;
    end

    // single iteration step for both the multiplier and the divider
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]}
                   + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
        w_mul_next = {w_mul_sum, r_acc[31:1]};
        w_div_sh   = r_acc[63:31];
        w_div_ok   = (w_div_sh >= {1'b0, r_opb});
        w_div_rem  = w_div_sh[31:0] - r_opb;
        w_div_next = {(w_div_ok ? w_div_rem : w_div_sh[31:0]),
                      r_acc[30:0], w_div_ok};
    end

    // sign correction and divide-by-zero override for the final write
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
        w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        if (!r_is_div) begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end else if (r_dbz) begin
            w_fix_hi = r_src_a;
            w_fix_lo = 32'hFFFF_FFFF;
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end
    end

    // FSM next-state: 32 iteration edges, then one fix edge
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_md_go)
                    w_next = bus.op[1] ? S_DIV : S_MUL;
            end
            S_MUL, S_DIV: begin
                if (r_cnt == 6'd31)
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // operand capture, iteration shadow registers and HI/LO update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_opb    <= 32'd0;
            r_src_a  <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            if (w_md_go) begin
                r_cnt    <= 6'd0;
                r_acc    <= {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
                r_opb    <= bus.op[1] ? w_abs_b : w_abs_a;
                r_src_a  <= bus.src_a;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_sgn & (bus.src_a[31] ^ bus.src_b[31]);
                r_neg_r  <= w_sgn & bus.src_a[31];
                r_dbz    <= bus.op[1] & (bus.src_b == 32'd0);
            end
            if (w_mthi)
                r_hi <= bus.src_a;
            if (w_mtlo)
                r_lo <= bus.src_a;
            if (r_state == S_MUL) begin
                r_acc <= w_mul_next;
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == S_DIV) begin
                r_acc <= w_div_next;
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == S_FIX) begin
                r_hi   <= w_fix_hi;
                r_lo   <= w_fix_lo;
                r_done <= 1'b1;
                r_dz   <= r_is_div & r_dbz;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus multi-cycle corner sequences
// for the HI/LO multiply-divide unit.
module tb_muldiv_unit;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // pulse start for one edge, scramble operands, then wait for done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int bcnt,
                          output bit got);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = b ^ 32'h5A5A_A5A5;
        bcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy)
                bcnt++;
        end
    endtask

    int  bc;
    bit  got;
    int  c0;
    int  c1;
    bit  seen;

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;

        vt[0]  = {3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1]  = {3'b001, 32'hFFFFFFFD, 32'h00000007,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[2]  = {3'b011, 32'hFFFFFFF9, 32'h00000002,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = {3'b010, 32'h00000005, 32'h00000000,
                  32'h00000005, 32'hFFFFFFFF, 1'b1};
        vt[4]  = {3'b011, 32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000, 1'b0};
        vt[5]  = {3'b010, 32'd100, 32'd7,
                  32'h00000002, 32'h0000000E, 1'b0};
        vt[6]  = {3'b001, 32'h80000000, 32'h80000000,
                  32'h40000000, 32'h00000000, 1'b0};
        vt[7]  = {3'b011, 32'h00000007, 32'hFFFFFFFE,
                  32'h00000001, 32'hFFFFFFFD, 1'b0};
        vt[8]  = {3'b011, 32'hFFFFFFFB, 32'h00000000,
                  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vt[9]  = {3'b000, 32'h12345678, 32'h00000009,
                  32'h00000000, 32'hA3D70A38, 1'b0};
        vt[10] = {3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h00000000, 32'h00000001, 1'b0};
        vt[11] = {3'b010, 32'hFFFFFFFF, 32'h00000010,
                  32'h0000000F, 32'h0FFFFFFF, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst dz", {31'd0, bus.div_by_zero}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, bc, got);
            chk($sformatf("v%0d done", i), {31'd0, got}, 32'd1);
            chk($sformatf("v%0d busy cycles", i), bc, 32'd33);
            chk($sformatf("v%0d hi", i), bus.hi, vt[i].hi);
            chk($sformatf("v%0d lo", i), bus.lo, vt[i].lo);
            chk($sformatf("v%0d dz", i), {31'd0, bus.div_by_zero},
                {31'd0, vt[i].dz});
            @(negedge clk);
            chk($sformatf("v%0d done width", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("v%0d dz width", i),
                {31'd0, bus.div_by_zero}, 32'd0);
        end

        for (int r = 6; r < 8; r++) begin
            bus.start = 1'b1;
            bus.op = r[2:0];
            bus.src_a = 32'hDEAD_BEEF;
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("rsv%0d busy", r), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("rsv%0d hi", r), bus.hi, 32'h0000000F);
            chk($sformatf("rsv%0d lo", r), bus.lo, 32'h0FFFFFFF);
        end

        bus.start = 1'b1;
        bus.op = 3'b100;
        bus.src_a = 32'h12345678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("mthi hi", bus.hi, 32'h12345678);
        chk("mthi busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("mthi done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        bus.op = 3'b000;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'b101;
        bus.src_a = 32'hAAAA5555;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo ignored lo", bus.lo, 32'h0FFFFFFF);
        chk("hold hi", bus.hi, 32'h12345678);
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mul34 done", {31'd0, got}, 32'd1);
        chk("mul34 hi", bus.hi, 32'd0);
        chk("mul34 lo", bus.lo, 32'h0000000C);
        @(negedge clk);

        bus.start = 1'b1;
        bus.op = 3'b010;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy)
                seen = 1'b1;
        end
        chk("abort no done", {31'd0, seen}, 32'd0);
        run_op(3'b010, 32'd100, 32'd7, bc, got);
        chk("post rst done", {31'd0, got}, 32'd1);
        chk("post rst lo", bus.lo, 32'h0000000E);
        chk("post rst hi", bus.hi, 32'h00000002);
        @(negedge clk);

        bus.start = 1'b1;
        bus.op = 3'b000;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        got = 1'b0;
        c0 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                c0 = cyc;
                break;
            end
        end
        chk("b2b first done", {31'd0, got}, 32'd1);
        chk("b2b first lo", bus.lo, 32'd6);
        bus.op = 3'b010;
        bus.src_a = 32'd9;
        bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        got = 1'b0;
        c1 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                c1 = cyc;
                break;
            end
        end
        chk("b2b second done", {31'd0, got}, 32'd1);
        chk("b2b second lo", bus.lo, 32'd3);
        chk("b2b second hi", bus.hi, 32'd0);
        chk("b2b spacing", c1 - c0, 32'd34);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
